// File: rtl/slot_reel_counter.sv
// slot_reel_counter: octal reel digit that advances at a prescaled rate while
// the sequencer holds `running`, then freezes, latches the final symbol,
// pulses result_valid and counts the completed spin. Also drives an
// active-low 7-segment pattern of the live digit, one clock behind it.
module slot_reel_counter #(
  parameter int DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       running,
  output logic [2:0] digit,
  output logic [2:0] stopped_digit,
  output logic       result_valid,
  output logic       spinning,
  output logic [7:0] spin_count,
  output logic [6:0] seg
);

  localparam logic [15:0] LP_LAST = 16'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPIN,
    S_STOPPED
  } state_t;

  state_t      r_state, w_state_nx;
  logic [15:0] r_presc, w_presc_nx;
  logic [2:0]  r_digit, w_digit_nx;
  logic [2:0]  r_stop,  w_stop_nx;
  logic        r_valid, w_valid_nx;
  logic [7:0]  r_count, w_count_nx;
  logic [6:0]  r_seg;

  // Active-low {g,f,e,d,c,b,a} pattern for one octal digit.
  function automatic logic [6:0] seg_of(input logic [2:0] d);
    logic [6:0] s;
    s = 7'h40;
    case (d)
      3'd0: s = 7'h40;
      3'd1: s = 7'h79;
      3'd2: s = 7'h24;
      3'd3: s = 7'h30;
      3'd4: s = 7'h19;
      3'd5: s = 7'h12;
      3'd6: s = 7'h02;
      3'd7: s = 7'h78;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // State and datapath registers; the async reset returns everything to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_digit <= '0;
      r_stop  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_presc <= w_presc_nx;
      r_digit <= w_digit_nx;
      r_stop  <= w_stop_nx;
      r_valid <= w_valid_nx;
      r_count <= w_count_nx;
    end
  end

  // Next-state logic: entry edge only clears the prescaler; a stop always
  // wins over a pending step, so the latched symbol is the pre-edge digit.
  always_comb begin
    w_state_nx = r_state;
    w_presc_nx = r_presc;
    w_digit_nx = r_digit;
    w_stop_nx  = r_stop;
    w_valid_nx = 1'b0;
    w_count_nx = r_count;
    case (r_state)
      S_IDLE, S_STOPPED: begin
        if (running) begin
          w_state_nx = S_SPIN;
          w_presc_nx = '0;
        end
      end
      S_SPIN: begin
        if (running) begin
          if (r_presc == LP_LAST) begin
            w_digit_nx = r_digit + 3'd1;
            w_presc_nx = '0;
          end else begin
            w_presc_nx = r_presc + 16'd1;
          end
        end else begin
          w_state_nx = S_STOPPED;
          w_stop_nx  = r_digit;
          w_valid_nx = 1'b1;
          w_count_nx = r_count + 8'd1;
          w_presc_nx = '0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Registered display decode, one clock behind the live digit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_seg <= 7'h40;
    else        r_seg <= seg_of(r_digit);
  end

  assign digit         = r_digit;
  assign stopped_digit = r_stop;
  assign result_valid  = r_valid;
  assign spinning      = (r_state == S_SPIN);
  assign spin_count    = r_count;
  assign seg           = r_seg;

endmodule

// File: tb/tb_slot_reel_counter.sv
// Directed bench for slot_reel_counter: one DIV=4 and one DIV=1 instance
// sharing clock and reset, driven with hand-computed expectations.
module tb_slot_reel_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       running4 = 1'b0;
  logic       running1 = 1'b0;
  logic [2:0] digit4, stop4, digit1, stop1;
  logic       valid4, spin4, valid1, spin1;
  logic [7:0] cnt4, cnt1;
  logic [6:0] seg4, seg1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  slot_reel_counter #(.DIV(4)) dut4 (
    .clock(clock), .reset(reset), .running(running4),
    .digit(digit4), .stopped_digit(stop4), .result_valid(valid4),
    .spinning(spin4), .spin_count(cnt4), .seg(seg4)
  );

  slot_reel_counter #(.DIV(1)) dut1 (
    .clock(clock), .reset(reset), .running(running1),
    .digit(digit1), .stopped_digit(stop1), .result_valid(valid1),
    .spinning(spin1), .spin_count(cnt1), .seg(seg1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_digit", 32'(digit4), 0);
    chk("rst_stop", 32'(stop4), 0);
    chk("rst_valid", 32'(valid4), 0);
    chk("rst_spin", 32'(spin4), 0);
    chk("rst_cnt", 32'(cnt4), 0);
    chk("rst_seg", 32'(seg4), 32'h40);

    // Continuous run of 33 edges from release: steps at 5,9,..., wrap at 33
    reset = 1'b1;
    running4 = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      tick();
      chk("run_novalid", 32'(valid4), 0);
      if (e == 1) begin
        chk("e1_spin", 32'(spin4), 1);
        chk("e1_digit", 32'(digit4), 0);
      end
      if (e == 4)  chk("e4_digit", 32'(digit4), 0);
      if (e == 5)  chk("e5_digit", 32'(digit4), 1);
      if (e == 5)  chk("e5_seg", 32'(seg4), 32'h40);
      if (e == 6)  chk("e6_seg", 32'(seg4), 32'h79);
      if (e == 9)  chk("e9_digit", 32'(digit4), 2);
      if (e == 32) chk("e32_digit", 32'(digit4), 7);
      if (e == 33) chk("e33_wrap", 32'(digit4), 0);
    end
    chk("run_cnt", 32'(cnt4), 0);

    // Async reset mid-spin, release with running high
    #1 reset = 1'b0;
    #1;
    chk("arst_spin", 32'(spin4), 0);
    chk("arst_seg", 32'(seg4), 32'h40);
    reset = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 11) running4 = 1'b0;
    end
    chk("stop12_spin", 32'(spin4), 0);
    chk("stop12_stopd", 32'(stop4), 2);
    chk("stop12_valid", 32'(valid4), 1);
    chk("stop12_cnt", 32'(cnt4), 1);
    chk("stop12_digit", 32'(digit4), 2);
    tick();
    chk("stop12_valid_off", 32'(valid4), 0);
    chk("stop12_hold", 32'(stop4), 2);

    // Restart resumes from 2; stop on the edge where prescaler == 3
    running4 = 1'b1;
    tick();
    chk("r2_spin", 32'(spin4), 1);
    chk("r2_digit", 32'(digit4), 2);
    repeat (4) tick();
    chk("r2_step", 32'(digit4), 3);
    repeat (3) tick();
    running4 = 1'b0;
    tick();
    chk("pstop_digit", 32'(digit4), 3);
    chk("pstop_stopd", 32'(stop4), 3);
    chk("pstop_valid", 32'(valid4), 1);
    chk("pstop_cnt", 32'(cnt4), 2);

    // Third spin to digit 5, count 3
    running4 = 1'b1;
    repeat (9) tick();
    chk("r3_digit", 32'(digit4), 5);
    running4 = 1'b0;
    tick();
    chk("r3_cnt", 32'(cnt4), 3);
    chk("r3_stopd", 32'(stop4), 5);

    // Reset asserted mid-spin with digit 5, count 3
    running4 = 1'b1;
    tick();
    chk("r4_spin", 32'(spin4), 1);
    #2 reset = 1'b0;
    #1;
    chk("mrst_digit", 32'(digit4), 0);
    chk("mrst_stopd", 32'(stop4), 0);
    chk("mrst_valid", 32'(valid4), 0);
    chk("mrst_spin", 32'(spin4), 0);
    chk("mrst_cnt", 32'(cnt4), 0);
    chk("mrst_seg", 32'(seg4), 32'h40);
    running4 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rel_valid", 32'(valid4), 0);
    chk("rel_cnt", 32'(cnt4), 0);
    chk("rel_spin", 32'(spin4), 0);

    // DIV=1: single-cycle running pulse
    running1 = 1'b1;
    tick();
    chk("d1p_spin", 32'(spin1), 1);
    chk("d1p_digit", 32'(digit1), 0);
    running1 = 1'b0;
    tick();
    chk("d1p_spin_off", 32'(spin1), 0);
    chk("d1p_valid", 32'(valid1), 1);
    chk("d1p_cnt", 32'(cnt1), 1);
    chk("d1p_digit2", 32'(digit1), 0);
    tick();
    chk("d1p_valid_off", 32'(valid1), 0);

    // DIV=1: steps every edge after entry
    running1 = 1'b1;
    tick();
    chk("d1r_e0", 32'(digit1), 0);
    tick();
    chk("d1r_e1", 32'(digit1), 1);
    tick();
    chk("d1r_e2", 32'(digit1), 2);
    running1 = 1'b0;
    tick();
    chk("d1r_stopd", 32'(stop1), 2);
    chk("d1r_cnt", 32'(cnt1), 2);

    // spin_count wrap: 253 more pulses -> 255, one more -> 0
    for (int i = 0; i < 253; i++) begin
      running1 = 1'b1;
      tick();
      running1 = 1'b0;
      tick();
    end
    chk("wrap_255", 32'(cnt1), 255);
    running1 = 1'b1;
    tick();
    running1 = 1'b0;
    tick();
    chk("wrap_0", 32'(cnt1), 0);
    chk("wrap_valid", 32'(valid1), 1);
    chk("wrap_digit", 32'(digit1), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
